// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the machine-level interrupt controller and the core trap logic.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package irq_ctrl_pkg;

    // Default number of external interrupt lines
    localparam int N_SRC_DEF = 8;

    // Claim IDs are 1..N_SRC for externals and TIMER_ID for the timer (max 31)
    localparam int ID_W = 5;

    // Word offsets on the peripheral bus
    localparam logic [2:0] OFF_PENDING  = 3'd0;
    localparam logic [2:0] OFF_ENABLE   = 3'd1;
    localparam logic [2:0] OFF_CLAIM    = 3'd2;
    localparam logic [2:0] OFF_COMPLETE = 3'd3;
    localparam logic [2:0] OFF_MTIME    = 3'd4;
    localparam logic [2:0] OFF_MTIMECMP = 3'd5;

    // mcause codes, shared with the trap logic
    localparam logic [3:0] CAUSE_M_EXT   = 4'd11;
    localparam logic [3:0] CAUSE_M_TIMER = 4'd7;

    // Request handshake towards the core
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index priority encoder over enabled pending sources; externals beat the timer.
// Latency: purely combinational.
// Backpressure: none.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC    = N_SRC_DEF,
    parameter int TIMER_ID = N_SRC + 1
) (
    input  logic [N_SRC-1:0] cand,
    input  logic             timer_pend,
    output logic [ID_W-1:0]  best_id
);

    // Scan from the top down so the lowest set index is the last assignment
    always_comb begin
        best_id = '0;
        if (timer_pend) begin
            best_id = ID_W'(TIMER_ID);
        end
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                best_id = ID_W'(i + 1);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Machine interrupt controller: edge-latched external lines, optional timer (IRQ_TIMER_EN), claim/complete regs.
// Latency: source edge to interrupt = 2 cycles; bus_ready/bus_rdata 1 cycle after bus_en.
// Backpressure: interrupt held until irq_taken; bus never stalls, every access completes next cycle.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC    = N_SRC_DEF,
    parameter int TIMER_ID = N_SRC + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] src_irq,
    input  logic             mie_in,
    input  logic             irq_taken,
    output logic             interrupt,
    output logic [3:0]       irq_code,
    input  logic             bus_en,
    input  logic             bus_we,
    input  logic [2:0]       bus_addr,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_ready
);

    logic [N_SRC-1:0] src_prev_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] enable_q, enable_d;
    logic [N_SRC-1:0] claim_clr;
    logic [ID_W-1:0]  claimed_id_q, claimed_id_d;
    logic [ID_W-1:0]  best_id;
    irq_state_e       state_q, state_d;
    logic             interrupt_q, interrupt_d;
    logic [3:0]       irq_code_q, irq_code_d;
    logic [3:0]       req_code;
    logic [31:0]      bus_rdata_q, bus_rdata_d;
    logic             bus_ready_q;
    logic             timer_pend;
    logic             rd_en, wr_en;
    logic             claim_rd, complete_hit;

    assign rd_en        = bus_en & ~bus_we;
    assign wr_en        = bus_en & bus_we;
    assign claim_rd     = rd_en && (bus_addr == OFF_CLAIM);
    assign complete_hit = wr_en && (bus_addr == OFF_COMPLETE) && (bus_wdata == 32'(claimed_id_q));

    irq_prio_enc #(
        .N_SRC    (N_SRC),
        .TIMER_ID (TIMER_ID)
    ) u_prio (
        .cand       (pending_q & enable_q),
        .timer_pend (timer_pend),
        .best_id    (best_id)
    );

`ifdef IRQ_TIMER_EN
    logic [31:0] mtime_q, mtime_d;
    logic [31:0] mtimecmp_q, mtimecmp_d;

    // Free-running counter; a bus write overrides the increment
    always_comb begin
        mtime_d    = mtime_q + 32'd1;
        mtimecmp_d = mtimecmp_q;
        if (wr_en && bus_addr == OFF_MTIME) begin
            mtime_d = bus_wdata;
        end
        if (wr_en && bus_addr == OFF_MTIMECMP) begin
            mtimecmp_d = bus_wdata;
        end
    end

    // Timer registers; compare starts at all-ones so the timer is quiet out of reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign timer_pend = (mtime_q >= mtimecmp_q);
    assign req_code   = (best_id == ID_W'(TIMER_ID)) ? CAUSE_M_TIMER : CAUSE_M_EXT;
`else
    assign timer_pend = 1'b0;
    assign req_code   = CAUSE_M_EXT;
`endif

    // Edge capture, claim clearing (new edge wins) and enable/claimed-ID updates
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            claim_clr[i] = claim_rd && (best_id == ID_W'(i + 1));
        end
        pending_d    = (pending_q & ~claim_clr) | (src_irq & ~src_prev_q);
        enable_d     = enable_q;
        claimed_id_d = claimed_id_q;
        if (wr_en && bus_addr == OFF_ENABLE) begin
            enable_d = bus_wdata[N_SRC-1:0];
        end
        if (claim_rd && best_id != '0) begin
            claimed_id_d = best_id;
        end
        if (complete_hit) begin
            claimed_id_d = '0;
        end
    end

    // Read mux; writes and idle cycles return zero
    always_comb begin
        bus_rdata_d = '0;
        if (rd_en) begin
            case (bus_addr)
                OFF_PENDING:  bus_rdata_d = 32'(pending_q);
                OFF_ENABLE:   bus_rdata_d = 32'(enable_q);
                OFF_CLAIM:    bus_rdata_d = 32'(best_id);
`ifdef IRQ_TIMER_EN
                OFF_MTIME:    bus_rdata_d = mtime_q;
                OFF_MTIMECMP: bus_rdata_d = mtimecmp_q;
`endif
                default:      bus_rdata_d = '0;
            endcase
        end
    end

    // Request FSM: raise, hold until taken or withdrawn, then wait for COMPLETE
    always_comb begin
        state_d     = state_q;
        interrupt_d = interrupt_q;
        irq_code_d  = irq_code_q;
        case (state_q)
            IDLE: begin
                if (best_id != '0 && mie_in) begin
                    state_d     = REQ;
                    interrupt_d = 1'b1;
                    irq_code_d  = req_code;
                end
            end
            REQ: begin
                if (irq_taken) begin
                    state_d     = SERVICE;
                    interrupt_d = 1'b0;
                end else if (best_id == '0 || !mie_in) begin
                    state_d     = IDLE;
                    interrupt_d = 1'b0;
                end
            end
            SERVICE: begin
                if (complete_hit) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                interrupt_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            src_prev_q   <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            claimed_id_q <= '0;
            state_q      <= IDLE;
            interrupt_q  <= 1'b0;
            irq_code_q   <= '0;
            bus_rdata_q  <= '0;
            bus_ready_q  <= 1'b0;
        end else begin
            src_prev_q   <= src_irq;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            claimed_id_q <= claimed_id_d;
            state_q      <= state_d;
            interrupt_q  <= interrupt_d;
            irq_code_q   <= irq_code_d;
            bus_rdata_q  <= bus_rdata_d;
            bus_ready_q  <= bus_en;
        end
    end

    assign interrupt = interrupt_q;
    assign irq_code  = irq_code_q;
    assign bus_rdata = bus_rdata_q;
    assign bus_ready = bus_ready_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Testbench for irq_ctrl: bus reads scored through an expected-value queue, handshake checked per scenario.
// Latency: n/a.
// Backpressure: n/a.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int NS = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NS-1:0] src_irq = '0;
    logic          mie_in = 1'b0;
    logic          irq_taken = 1'b0;
    logic          interrupt;
    logic [3:0]    irq_code;
    logic          bus_en = 1'b0;
    logic          bus_we = 1'b0;
    logic [2:0]    bus_addr = '0;
    logic [31:0]   bus_wdata = '0;
    logic [31:0]   bus_rdata;
    logic          bus_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] exp;
        string       tag;
    } sb_t;
    sb_t sb_q[$];

    irq_ctrl #(.N_SRC(NS)) dut (
        .clk       (clk),
        .rst       (rst),
        .src_irq   (src_irq),
        .mie_in    (mie_in),
        .irq_taken (irq_taken),
        .interrupt (interrupt),
        .irq_code  (irq_code),
        .bus_en    (bus_en),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready)
    );

    always #5 clk = ~clk;

    // Scoreboard: every bus response is matched against the oldest expected value
    always @(negedge clk) begin
        sb_t e;
        if (bus_ready === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL bus_unexpected: rdata=%h with nothing expected", bus_rdata);
            end else begin
                e = sb_q.pop_front();
                if (bus_rdata !== e.exp) begin
                    bad++;
                    $display("FAIL %s: rdata=%h expected=%h", e.tag, bus_rdata, e.exp);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus access; the expected response is queued before the DUT samples it
    task automatic bus_xfer(input logic we, input logic [2:0] addr, input logic [31:0] wd,
                            input logic [31:0] exp, input string tag);
        sb_t e;
        e.exp = exp;
        e.tag = tag;
        sb_q.push_back(e);
        bus_en    = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wd;
        @(negedge clk);
        bus_en = 1'b0;
        bus_we = 1'b0;
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL %s_ready: %0d responses outstanding, expected 0", tag, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        bus_xfer(1'b0, addr, 32'h0, exp, tag);
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] wd, input string tag);
        bus_xfer(1'b1, addr, wd, 32'h0, tag);
    endtask

    task automatic pulse(input logic [NS-1:0] m);
        src_irq = m;
        cyc(1);
        src_irq = '0;
    endtask

    task automatic take();
        irq_taken = 1'b1;
        cyc(1);
        irq_taken = 1'b0;
    endtask

    task automatic wait_irq(input int lim, output int n);
        n = 0;
        while (interrupt !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] cmp_rst;
`ifdef IRQ_TIMER_EN
        cmp_rst = 32'hFFFF_FFFF;
`else
        cmp_rst = 32'h0;
`endif
        rst = 1'b1;
        cyc(3);
        total++;
        if (interrupt !== 1'b0 || irq_code !== 4'd0 || bus_ready !== 1'b0 || bus_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs: int=%b code=%0d rdy=%b rdata=%h expected all 0",
                     interrupt, irq_code, bus_ready, bus_rdata);
        end
        rst = 1'b0;
        rd(OFF_PENDING, 32'h0, "reset_pending");
        rd(OFF_ENABLE, 32'h0, "reset_enable");
        rd(OFF_CLAIM, 32'h0, "reset_claim");
        rd(OFF_MTIMECMP, cmp_rst, "reset_mtimecmp");
`ifndef IRQ_TIMER_EN
        rd(OFF_MTIME, 32'h0, "no_timer_mtime");
`endif
        wr(3'd6, 32'hDEAD_BEEF, "wr_unmapped");
        rd(3'd6, 32'h0, "rd_off6");
        rd(3'd7, 32'h0, "rd_off7");
    endtask

    task automatic test_single();
        wr(OFF_ENABLE, 32'hFFFF_FF05, "enable_wr");
        rd(OFF_ENABLE, 32'h0000_0005, "enable_upper_masked");
        mie_in  = 1'b1;
        src_irq = 8'h04;
        cyc(1);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL single_early: interrupt=%b expected 0", interrupt);
        end
        src_irq = '0;
        cyc(1);
        total++;
        if (interrupt !== 1'b1 || irq_code !== CAUSE_M_EXT) begin
            bad++;
            $display("FAIL single_raise: interrupt=%b code=%0d expected 1/11", interrupt, irq_code);
        end
        for (int k = 0; k < 5; k++) begin
            cyc(1);
            total++;
            if (interrupt !== 1'b1 || irq_code !== CAUSE_M_EXT) begin
                bad++;
                $display("FAIL single_hold[%0d]: interrupt=%b code=%0d expected 1/11", k, interrupt, irq_code);
            end
        end
        take();
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL single_taken_drop: interrupt=%b expected 0", interrupt);
        end
        rd(OFF_PENDING, 32'h4, "single_pend_before_claim");
        rd(OFF_CLAIM, 32'd3, "single_claim");
        rd(OFF_PENDING, 32'h0, "single_pend_after_claim");
        pulse(8'h01);
        cyc(3);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL single_service_blocks: interrupt=%b expected 0", interrupt);
        end
        wr(OFF_COMPLETE, 32'd3, "single_complete");
        cyc(1);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL single_next_after_complete: interrupt=%b expected 1", interrupt);
        end
        take();
        rd(OFF_CLAIM, 32'd1, "single_claim_src0");
        wr(OFF_COMPLETE, 32'd1, "single_complete_src0");
    endtask

    task automatic test_simultaneous();
        pulse(8'h05);
        cyc(1);
        total++;
        if (interrupt !== 1'b1 || irq_code !== CAUSE_M_EXT) begin
            bad++;
            $display("FAIL simul_raise: interrupt=%b code=%0d expected 1/11", interrupt, irq_code);
        end
        take();
        rd(OFF_CLAIM, 32'd1, "simul_claim_low_first");
        cyc(3);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL simul_second_waits: interrupt=%b expected 0", interrupt);
        end
        rd(OFF_PENDING, 32'h4, "simul_pend_left");
        wr(OFF_COMPLETE, 32'd1, "simul_complete_1");
        cyc(1);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL simul_second_req: interrupt=%b expected 1", interrupt);
        end
        take();
        rd(OFF_CLAIM, 32'd3, "simul_claim_second");
        wr(OFF_COMPLETE, 32'd3, "simul_complete_3");
    endtask

    task automatic test_mie_complete();
        int n;
        pulse(8'h04);
        wait_irq(10, n);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL mie_req: interrupt=%b after %0d cycles expected 1", interrupt, n);
        end
        mie_in = 1'b0;
        cyc(1);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL mie_drop: interrupt=%b expected 0", interrupt);
        end
        mie_in = 1'b1;
        cyc(1);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL mie_rerequest: interrupt=%b expected 1", interrupt);
        end
        take();
        rd(OFF_CLAIM, 32'd3, "mie_claim");
        pulse(8'h01);
        wr(OFF_COMPLETE, 32'd5, "complete_wrong_wr");
        cyc(3);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL complete_wrong_ignored: interrupt=%b expected 0", interrupt);
        end
        wr(OFF_COMPLETE, 32'd3, "complete_right_wr");
        cyc(1);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL complete_right: interrupt=%b expected 1", interrupt);
        end
        take();
        rd(OFF_CLAIM, 32'd1, "mie_claim_src0");
        wr(OFF_COMPLETE, 32'd1, "mie_complete_src0");
    endtask

    task automatic test_enable_drop();
        int n;
        pulse(8'h04);
        wait_irq(10, n);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL en_req: interrupt=%b after %0d cycles expected 1", interrupt, n);
        end
        wr(OFF_ENABLE, 32'h0, "en_clear_wr");
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL en_clear_lag: interrupt=%b expected 1", interrupt);
        end
        cyc(1);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL en_clear_drop: interrupt=%b expected 0", interrupt);
        end
        wr(OFF_ENABLE, 32'h5, "en_restore_wr");
        pulse(8'h02);
        cyc(2);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL en_restore_req: interrupt=%b expected 1", interrupt);
        end
        rd(OFF_PENDING, 32'h6, "en_pend_masked");
        take();
        rd(OFF_CLAIM, 32'd3, "en_claim");
        rd(OFF_CLAIM, 32'd0, "en_claim_disabled_only");
        wr(OFF_COMPLETE, 32'd3, "en_complete");
    endtask

`ifdef IRQ_TIMER_EN
    task automatic test_timer();
        int n;
        mie_in = 1'b0;
        wr(OFF_MTIME, 32'hFFFF_FFFF, "mtime_wr_max");
        rd(OFF_MTIME, 32'hFFFF_FFFF, "mtime_rd_max");
        rd(OFF_MTIME, 32'h0, "mtime_wrap");
        mie_in = 1'b1;
        wr(OFF_MTIME, 32'd100, "mtime_wr");
        wr(OFF_MTIMECMP, 32'd110, "mtimecmp_wr");
        wait_irq(30, n);
        total++;
        if (interrupt !== 1'b1 || irq_code !== CAUSE_M_TIMER || n != 10) begin
            bad++;
            $display("FAIL timer_raise: interrupt=%b code=%0d cycles=%0d expected 1/7/10", interrupt, irq_code, n);
        end
        wr(OFF_MTIMECMP, 32'hFFFF_FFFF, "timer_cmp_clear");
        cyc(1);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL timer_withdraw: interrupt=%b expected 0", interrupt);
        end
        wr(OFF_MTIMECMP, 32'h0, "timer_cmp_zero");
        cyc(1);
        total++;
        if (interrupt !== 1'b1 || irq_code !== CAUSE_M_TIMER) begin
            bad++;
            $display("FAIL timer_req2: interrupt=%b code=%0d expected 1/7", interrupt, irq_code);
        end
        take();
        rd(OFF_CLAIM, 32'(NS + 1), "timer_claim");
        wr(OFF_MTIMECMP, 32'hFFFF_FFFF, "timer_cmp_ack");
        wr(OFF_COMPLETE, 32'(NS + 1), "timer_complete");
        cyc(2);
        total++;
        if (interrupt !== 1'b0) begin
            bad++;
            $display("FAIL timer_done: interrupt=%b expected 0", interrupt);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int n;
        pulse(8'h01);
        wait_irq(10, n);
        total++;
        if (interrupt !== 1'b1) begin
            bad++;
            $display("FAIL rmid_req: interrupt=%b after %0d cycles expected 1", interrupt, n);
        end
        take();
        rd(OFF_CLAIM, 32'd1, "rmid_claim");
        pulse(8'h04);
        cyc(1);
        rst = 1'b1;
        cyc(1);
        total++;
        if (interrupt !== 1'b0 || bus_ready !== 1'b0 || dut.claimed_id_q !== 5'd0 || dut.state_q !== IDLE) begin
            bad++;
            $display("FAIL rmid_reset: int=%b rdy=%b claimed=%0d state=%0d expected 0/0/0/IDLE",
                     interrupt, bus_ready, dut.claimed_id_q, dut.state_q);
        end
        rst = 1'b0;
        rd(OFF_PENDING, 32'h0, "rmid_pending");
        rd(OFF_ENABLE, 32'h0, "rmid_enable");
        rd(OFF_CLAIM, 32'h0, "rmid_claim_none");
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_mie_complete();
        test_enable_drop();
`ifdef IRQ_TIMER_EN
        test_timer();
`endif
        test_reset_mid();
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Machine-level interrupt source for the pipelined core.
- Latches external interrupt lines and an optional machine timer.
- Arbitrates pending sources and drives the core's `interrupt` input with a request/accept handshake.
- Exposes pending, enable, claim, complete and timer registers on a word-addressed peripheral bus driven from the MEM stage.
- Complements the core's trap logic: this block raises interrupts; the trap logic consumes them and redirects the PC.

Parameters:
N_SRC, 8, number of external interrupt lines (1..30)
TIMER_ID, N_SRC+1, claim ID reported for the timer source

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
src_irq  in  N_SRC  external lines, synchronous to clk, level
mie_in  in  1  mstatus.MIE from CSR file; gates requests
irq_taken  in  1  core accepted the trap this cycle
interrupt  out  1  registered interrupt request to core
irq_code  out  4  mcause code for the request: 11 external, 7 timer
bus_en  in  1  bus access strobe
bus_we  in  1  1 write, 0 read
bus_addr  in  3  word offset
bus_wdata  in  32  write data
bus_rdata  out  32  registered read data
bus_ready  out  1  access done, one cycle after bus_en

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: all outputs 0; pending=0, enable=0, claimed_id=0; FSM in IDLE; mtime=0; mtimecmp=0xFFFF_FFFF.
- Pending capture: pending[i] sets on a rising edge of src_irq[i]. The previous line value is held in a register.
- Claim: pending[i] clears when CLAIM returns ID i+1.
- Simultaneous set and clear of the same bit: set wins.
- Timer pending (level): timer_pend = (mtime >= mtimecmp). Comparison is unsigned 32-bit.
- mtime increments every cycle and wraps 0xFFFF_FFFF -> 0.
- Arbitration: candidates = pending & enable, plus timer_pend.
  - External sources beat the timer.
  - Among externals, the lowest index wins.
  - Result best_id: 0 means none.
- Register map (word offsets):
  - 0 PENDING: RO.
  - 1 ENABLE: RW, bits N_SRC-1:0; upper bits read 0.
  - 2 CLAIM: RO with side effect. Returns best_id and clears that external pending bit. Sets claimed_id when nonzero.
  - 3 COMPLETE: WO. A write whose value equals claimed_id ends service; a mismatched value is ignored.
  - 4 MTIME: RW.
  - 5 MTIMECMP: RW.
  - 6, 7: read 0, writes ignored.
  - A write to MTIME takes priority over the increment in the same cycle.
- Bus timing: bus_ready pulses 1 cycle after bus_en. bus_rdata is valid with bus_ready; it reads 0 for writes.
- FSM states and transitions:
  - IDLE -> REQ when best_id!=0 and mie_in=1. interrupt=1 and irq_code are set in the same transition (registered).
  - REQ: interrupt is held while irq_taken=0. If best_id drops to 0 (timer cleared or enable cleared) or mie_in=0, go to IDLE and drop interrupt; no stale trap.
  - REQ + irq_taken -> SERVICE; interrupt=0 the next cycle. This gives exactly one accepted cycle, so there is no double trap.
  - SERVICE: no new request. Exit to IDLE on a matching COMPLETE write; claimed_id clears to 0.
  - For timer service, CLAIM returns TIMER_ID; clearing is by a MTIMECMP write, then COMPLETE with TIMER_ID.
- irq_code freezes while in REQ.
- Reset mid-operation returns to IDLE with all state cleared in the same cycle.

Optional Feature:
- Macro: IRQ_TIMER_EN.
- Defined: mtime/mtimecmp logic is present and the timer participates in arbitration.
- Undefined: no counter or compare logic; timer_pend=0; offsets 4/5 behave like 6/7; irq_code is always 11.

Decomposition:
- Shared package holds:
  - Register offset constants.
  - The state enum IDLE/REQ/SERVICE.
  - mcause code constants CAUSE_M_EXT=11 and CAUSE_M_TIMER=7.
  - N_SRC default.
- The trap logic imports the same cause constants.
- One sub-module: irq_prio_enc, a combinational lowest-index priority encoder producing best_id.

Test Plan:
- Reset, then read all offsets: PENDING=0, ENABLE=0, MTIMECMP=0xFFFFFFFF, interrupt=0.
- ENABLE=0x5, pulse src_irq[2], mie_in=1: interrupt=1 two cycles later with irq_code=11. Hold irq_taken=0 for 5 cycles: interrupt stays 1. irq_taken=1 for 1 cycle: interrupt=0 next cycle. CLAIM reads 3; COMPLETE 3 returns the FSM to IDLE.
- Pulse src[0] and src[2] in the same cycle: CLAIM reads 1 and then 3. A second source requests only after COMPLETE 1.
- IRQ_TIMER_EN, MTIME=100, MTIMECMP=110: interrupt rises about cycle 10 with irq_code=7. Write MTIMECMP=0xFFFFFFFF before irq_taken: interrupt drops and the FSM returns to IDLE.
- In REQ, drop mie_in: interrupt=0 next cycle. Restore mie_in: re-request. COMPLETE with wrong ID 5 is ignored and the FSM stays in SERVICE.
- Assert rst during SERVICE: next cycle interrupt=0, claimed_id=0, pending=0.
